// File: rtl/multiword_serial_adder.sv
// Streaming multi-word adder: one WIDTH-bit word per cycle, LS word first, with the
// carry chained through a register and a single registered valid/ready output stage.

// Parallel-prefix (Kogge-Stone) carry-lookahead slice. The incoming carry is folded
// into bit 0's generate term so every prefix group already accounts for it.
module carry_lookahead_adder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int LEVELS = $clog2(WIDTH);

  always_comb begin : prefix
    logic [WIDTH-1:0] gen;
    logic [WIDTH-1:0] prop;
    logic [WIDTH-1:0] gen_n;
    logic [WIDTH-1:0] prop_n;
    logic [WIDTH-1:0] carry;

    gen    = a & b;
    prop   = a ^ b;
    gen[0] = gen[0] | (prop[0] & cin);

    for (int l = 0; l < LEVELS; l++) begin
      gen_n  = gen;
      prop_n = prop;
      for (int i = (1 << l); i < WIDTH; i++) begin
        gen_n[i]  = gen[i] | (prop[i] & gen[i - (1 << l)]);
        prop_n[i] = prop[i] & prop[i - (1 << l)];
      end
      gen  = gen_n;
      prop = prop_n;
    end

    // After the prefix tree, gen[i] is the carry out of bit i.
    carry[0] = cin;
    for (int i = 1; i < WIDTH; i++) begin
      carry[i] = gen[i-1];
    end

    sum  = (a ^ b) ^ carry;
    cout = gen[WIDTH-1];
  end

endmodule

module multiword_serial_adder #(
  parameter int WIDTH = 8,
  parameter int WORDS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_word,
  input  logic [WIDTH-1:0] b_word,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum_word,
  output logic             out_last,
  output logic             carry_out,
  output logic             overflow
);

  localparam int CNT_W = $clog2(WORDS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORDS - 1);

  if (WORDS < 2) begin : g_bad_words
    $error("multiword_serial_adder: WORDS must be at least 2");
  end

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] sum;
    logic             last;
    logic             cout;
    logic             ovf;
  } out_reg_t;

  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             carry_q, carry_nxt;
  out_reg_t         out_q, out_nxt;

  logic             accept;
  logic             is_last;
  logic             slice_cin;
  logic [WIDTH-1:0] slice_sum;
  logic             slice_cout;
  logic             word_ovf;

  assign in_ready  = !rst && (!out_q.valid || out_ready);
  assign accept    = in_valid && in_ready && !clr;
  assign is_last   = (cnt == LAST_CNT);
  assign slice_cin = (cnt == '0) ? carry_in : carry_q;

  carry_lookahead_adder #(.WIDTH(WIDTH)) u_cla (
    .a    (a_word),
    .b    (b_word),
    .cin  (slice_cin),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  // Signed overflow of the full-width sum is decided entirely by the MS word.
  assign word_ovf = (a_word[WIDTH-1] == b_word[WIDTH-1]) &&
                    (slice_sum[WIDTH-1] != a_word[WIDTH-1]);

  always_comb begin
    // NOTE: every next-state variable gets its hold value first, so no path leaves
    // one unassigned and no latch is inferred.
    cnt_nxt   = cnt;
    carry_nxt = carry_q;
    out_nxt   = out_q;

    if (clr) begin
      cnt_nxt      = '0;
      carry_nxt    = 1'b0;
      out_nxt.valid = 1'b0;
      out_nxt.last  = 1'b0;
      out_nxt.cout  = 1'b0;
      out_nxt.ovf   = 1'b0;
    end else if (accept) begin
      cnt_nxt       = is_last ? '0 : cnt + CNT_W'(1);
      carry_nxt     = slice_cout;
      out_nxt.valid = 1'b1;
      out_nxt.sum   = slice_sum;
      out_nxt.last  = is_last;
      out_nxt.cout  = is_last && slice_cout;
      out_nxt.ovf   = is_last && word_ovf;
    end else if (out_q.valid && out_ready) begin
      out_nxt.valid = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      carry_q <= 1'b0;
      out_q   <= '0;
    end else begin
      cnt     <= cnt_nxt;
      carry_q <= carry_nxt;
      out_q   <= out_nxt;
    end
  end

  assign out_valid = out_q.valid;
  assign sum_word  = out_q.sum;
  assign out_last  = out_q.last;
  assign carry_out = out_q.cout;
  assign overflow  = out_q.ovf;

endmodule

// File: tb/tb_multiword_serial_adder.sv
// Randomized and directed bench for multiword_serial_adder; expected words come from
// full-width integer addition of the whole operands.
module tb_multiword_serial_adder;

  localparam int W     = 8;
  localparam int N     = 4;
  localparam int TOTAL = W * N;

  typedef struct {
    logic [W-1:0] sum;
    logic         last;
    logic         cout;
    logic         ovf;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         clr;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a_word;
  logic [W-1:0] b_word;
  logic         carry_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum_word;
  logic         out_last;
  logic         carry_out;
  logic         overflow;

  int   checks   = 0;
  int   failures = 0;
  exp_t exp_q[$];
  bit   mon_en     = 0;
  bit   rand_ready = 0;
  int   stall_cnt  = 0;
  bit   hold_prev  = 0;
  logic [W-1:0] prev_sum;
  logic         prev_last;
  logic         prev_cout;
  logic         prev_ovf;

  multiword_serial_adder #(.WIDTH(W), .WORDS(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_word    (a_word),
    .b_word    (b_word),
    .carry_in  (carry_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum_word  (sum_word),
    .out_last  (out_last),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got=running required=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h required=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model_word(input logic [TOTAL-1:0] a, input logic [TOTAL-1:0] b,
                                      input logic ci, input int k);
    logic [TOTAL:0] full;
    exp_t r;
    full   = {1'b0, a} + {1'b0, b} + {{TOTAL{1'b0}}, ci};
    r.sum  = full[k*W +: W];
    r.last = (k == N - 1);
    r.cout = r.last ? full[TOTAL] : 1'b0;
    r.ovf  = r.last ? ((a[TOTAL-1] == b[TOTAL-1]) && (full[TOTAL-1] != a[TOTAL-1])) : 1'b0;
    return r;
  endfunction

  // Consumer: out_ready changes 2 time units after each rising edge.
  always @(posedge clk) begin
    #2;
    if (stall_cnt > 0) begin
      out_ready = 1'b0;
      stall_cnt--;
    end else if (rand_ready) begin
      out_ready = ($urandom_range(0, 3) != 0);
    end else begin
      out_ready = 1'b1;
    end
  end

  // Output monitor: compares against the scoreboard on every falling edge.
  always @(negedge clk) begin
    if (mon_en) begin
      check("in_ready", 64'(in_ready), 64'(!rst && (exp_q.size() == 0 || out_ready)));
      check("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
      if (out_valid && exp_q.size() != 0) begin
        check("sum_word", 64'(sum_word), 64'(exp_q[0].sum));
        check("out_last", 64'(out_last), 64'(exp_q[0].last));
        check("carry_out", 64'(carry_out), 64'(exp_q[0].cout));
        check("overflow", 64'(overflow), 64'(exp_q[0].ovf));
      end
      if (hold_prev) begin
        check("stall_sum_stable", 64'(sum_word), 64'(prev_sum));
        check("stall_last_stable", 64'(out_last), 64'(prev_last));
        check("stall_tags_stable", 64'({carry_out, overflow}), 64'({prev_cout, prev_ovf}));
      end
      hold_prev = out_valid && !out_ready && !rst;
      prev_sum  = sum_word;
      prev_last = out_last;
      prev_cout = carry_out;
      prev_ovf  = overflow;
      if (out_valid && out_ready && !rst && exp_q.size() != 0) void'(exp_q.pop_front());
    end
  end

  // Presents one word-pair and returns 1 time unit after the edge that accepted it.
  task automatic drive_word(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                            output bit ok);
    int budget;
    budget   = 0;
    ok       = 0;
    a_word   = a;
    b_word   = b;
    carry_in = ci;
    in_valid = 1'b1;
    while (!ok) begin
      @(negedge clk);
      if (in_ready && !clr) ok = 1;
      else begin
        budget++;
        if (budget >= 64) break;
      end
    end
    if (ok) begin
      @(posedge clk);
      #1;
    end else begin
      check("accept_timeout", 64'(in_ready), 64'd1);
    end
    in_valid = 1'b0;
  endtask

  task automatic send_txn(input logic [TOTAL-1:0] a, input logic [TOTAL-1:0] b,
                          input logic ci, input bit stall_w1, input int max_gap);
    bit ok;
    int gap;
    for (int k = 0; k < N; k++) begin
      // carry_in on later words is randomized: it must be ignored.
      drive_word(a[k*W +: W], b[k*W +: W], (k == 0) ? ci : 1'($urandom_range(0, 1)), ok);
      if (!ok) return;
      exp_q.push_back(model_word(a, b, ci, k));
      if (stall_w1 && k == 1) stall_cnt = 3;
      gap = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
      if (gap > 0) begin
        repeat (gap) @(posedge clk);
        #1;
      end
    end
  endtask

  initial begin
    bit ok;
    logic [63:0] r;
    logic [TOTAL-1:0] a, b;

    rst       = 1'b1;
    clr       = 1'b0;
    in_valid  = 1'b0;
    a_word    = '0;
    b_word    = '0;
    carry_in  = 1'b0;
    out_ready = 1'b1;

    #2;
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_sum_word", 64'(sum_word), 64'd0);
    check("rst_tags", 64'({out_last, carry_out, overflow}), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("in_ready_after_rst", 64'(in_ready), 64'd1);
    mon_en = 1;
    @(posedge clk);
    #1;

    // Directed vectors with an always-ready consumer.
    send_txn(32'h0000_00FF, 32'h0000_0001, 1'b0, 0, 0);
    send_txn(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 0, 0);
    send_txn(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 0, 0);
    send_txn(32'h0000_0001, 32'h0000_0001, 1'b0, 0, 0);
    send_txn(32'h8000_0000, 32'h8000_0000, 1'b0, 0, 0);

    // Backpressure: three stalled cycles after word 1 is output.
    send_txn(32'h1234_56FF, 32'h0FED_CB01, 1'b1, 1, 0);

    // Flush in the cycle after word 1 is accepted, with a word still offered.
    a = 32'hAABB_CCDD;
    b = 32'h1122_3344;
    drive_word(a[7:0], b[7:0], 1'b0, ok);
    if (ok) exp_q.push_back(model_word(a, b, 1'b0, 0));
    drive_word(a[15:8], b[15:8], 1'b0, ok);
    if (ok) exp_q.push_back(model_word(a, b, 1'b0, 1));
    a_word   = a[23:16];
    b_word   = b[23:16];
    in_valid = 1'b1;
    clr      = 1'b1;
    @(posedge clk);
    #1;
    clr      = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    hold_prev = 0;
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_out_last", 64'(out_last), 64'd0);
    send_txn(32'h0000_0003, 32'h0000_0004, 1'b1, 0, 0);

    // Asynchronous reset in the middle of word 2.
    a = 32'h0F0F_F0F0;
    b = 32'h0101_1F1F;
    drive_word(a[7:0], b[7:0], 1'b1, ok);
    if (ok) exp_q.push_back(model_word(a, b, 1'b1, 0));
    drive_word(a[15:8], b[15:8], 1'b0, ok);
    if (ok) exp_q.push_back(model_word(a, b, 1'b1, 1));
    a_word   = a[23:16];
    b_word   = b[23:16];
    in_valid = 1'b1;
    #2;
    rst = 1'b1;
    exp_q.delete();
    hold_prev = 0;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_sum_word", 64'(sum_word), 64'd0);
    check("arst_tags", 64'({out_last, carry_out, overflow}), 64'd0);
    check("arst_in_ready", 64'(in_ready), 64'd0);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b0;
    send_txn(32'hDEAD_BEEF, 32'h2152_4111, 1'b1, 0, 0);

    // Randomized traffic with random gaps and a random consumer.
    rand_ready = 1;
    for (int t = 0; t < 150; t++) begin
      r = {$urandom, $urandom};
      a = r[TOTAL-1:0];
      r = {$urandom, $urandom};
      b = r[TOTAL-1:0];
      case ($urandom_range(0, 7))
        0: a = '1;
        1: b = ~a;
        2: begin a = {1'b0, {(TOTAL-1){1'b1}}}; b = TOTAL'(1); end
        3: begin a = {1'b1, {(TOTAL-1){1'b0}}}; b = a; end
        default: ;
      endcase
      send_txn(a, b, 1'($urandom_range(0, 1)), 0, (t % 3 == 0) ? 2 : 0);
    end

    rand_ready = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
